// File: rtl/ext_mem_model_burst_if.sv
// Request, write-data and read-response bundle between the cache/memory arbiter
// (master) and the external memory model (slave).
interface ext_mem_model_burst_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5
);
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_rw;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic [TAG_BITS-1:0]    mem_req_tag;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic                   mem_resp_ready;
    logic [DATA_BITS-1:0]   mem_resp_data;
    logic [TAG_BITS-1:0]    mem_resp_tag;
    logic                   mem_resp_last;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_resp_ready,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_tag, mem_resp_last
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_resp_ready,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_tag, mem_resp_last
    );
endinterface

// File: rtl/ext_mem_model_burst.sv
// Burst external-memory model: request FIFO, programmable read latency, masked write bursts.
// Define EXT_MEM_WRAP_FIRST_EN for critical-word-first read bursts.
module ext_mem_model_burst #(
    parameter int ADDR_BITS    = 28,
    parameter int DATA_BITS    = 128,
    parameter int TAG_BITS     = 5,
    parameter int DEPTH_LOG2   = 21,
    parameter int BURST_LEN    = 4,
    parameter int READ_LATENCY = 2,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ext_mem_model_burst_if.slave bus
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam int NB = DATA_BITS / 8;
    localparam logic [BW-1:0]         BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [LW-1:0]         LAT_LAST  = LW'(READ_LATENCY);
    localparam logic [QW:0]           Q_FULL    = (QW + 1)'(QUEUE_DEPTH);
    localparam logic [DEPTH_LOG2-1:0] BASE_MASK = ~DEPTH_LOG2'(BURST_LEN - 1);
`ifdef EXT_MEM_WRAP_FIRST_EN
    localparam bit WRAP_FIRST = 1'b1;
`else
    localparam bit WRAP_FIRST = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LAT, S_READ, S_WRITE} state_t;

    logic                 fifo_rw_q   [QUEUE_DEPTH];
    logic [ADDR_BITS-1:0] fifo_addr_q [QUEUE_DEPTH];
    logic [TAG_BITS-1:0]  fifo_tag_q  [QUEUE_DEPTH];
    logic [QW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [QW:0]          count_q;
    logic                 full, empty, enq, deq;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [TAG_BITS-1:0]  tag_q, tag_d;
    logic [LW-1:0]        lat_q, lat_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [BW-1:0]        sent_q, sent_d;
    logic                 resp_valid, data_ready, wr_fire;
    logic [ADDR_BITS-1:0] head_addr;
    logic [DEPTH_LOG2-1:0] beat_addr;
    logic [DATA_BITS-1:0] mem_q [2**DEPTH_LOG2];
    logic                 unused_addr;

    assign full      = (count_q == Q_FULL);
    assign empty     = (count_q == '0);
    assign enq       = bus.mem_req_valid && bus.mem_req_ready;
    assign head_addr = fifo_addr_q[rd_ptr_q];

    // A full FIFO refuses new requests even when the head leaves in the same cycle.
    assign bus.mem_req_ready = !reset && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rw_q[wr_ptr_q]   <= bus.mem_req_rw;
            fifo_addr_q[wr_ptr_q] <= bus.mem_req_addr;
            fifo_tag_q[wr_ptr_q]  <= bus.mem_req_tag;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        lat_d      = lat_q;
        beat_d     = beat_q;
        sent_d     = sent_q;
        deq        = 1'b0;
        resp_valid = 1'b0;
        data_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    deq    = 1'b1;
                    addr_d = head_addr;
                    tag_d  = fifo_tag_q[rd_ptr_q];
                    sent_d = '0;
                    if (fifo_rw_q[rd_ptr_q]) begin
                        state_d = S_WRITE;
                        beat_d  = '0;
                    end else begin
                        state_d = S_LAT;
                        lat_d   = LW'(1);
                        beat_d  = WRAP_FIRST ? (head_addr[BW-1:0] & BEAT_LAST) : '0;
                    end
                end
            end
            S_LAT: begin
                lat_d = lat_q + 1'b1;
                if (lat_q == LAT_LAST) state_d = S_READ;
            end
            S_READ: begin
                resp_valid = 1'b1;
                if (bus.mem_resp_ready) begin
                    beat_d = (beat_q + 1'b1) & BEAT_LAST;
                    sent_d = sent_q + 1'b1;
                    if (sent_q == BEAT_LAST) state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                data_ready = 1'b1;
                if (bus.mem_req_data_valid) begin
                    beat_d = (beat_q + 1'b1) & BEAT_LAST;
                    if (beat_q == BEAT_LAST) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            sent_q  <= sent_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        tag_q  <= tag_d;
    end

    assign beat_addr = (addr_q[DEPTH_LOG2-1:0] & BASE_MASK) | DEPTH_LOG2'(beat_q);
    assign wr_fire   = bus.mem_req_data_valid && bus.mem_req_data_ready;

    // Byte-masked write: disabled lanes keep their previous contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.mem_req_data_mask[b])
                    mem_q[beat_addr][b*8 +: 8] <= bus.mem_req_data_bits[b*8 +: 8];
            end
        end
    end

    assign bus.mem_req_data_ready = !reset && data_ready;
    assign bus.mem_resp_valid     = !reset && resp_valid;
    assign bus.mem_resp_data      = mem_q[beat_addr];
    assign bus.mem_resp_tag       = tag_q;
    assign bus.mem_resp_last      = bus.mem_resp_valid && (sent_q == BEAT_LAST);

    assign unused_addr = ^addr_q;
endmodule

// File: tb/tb_ext_mem_model_burst.sv
// Directed bench for ext_mem_model_burst; a transaction-level memory/ordering model
// checks every response beat, with literal expectations per scenario.
`timescale 1ns/1ps
module tb_ext_mem_model_burst;
    localparam int AB = 28, DB = 128, TB = 5, DL = 12, BL = 4, RL = 2, QD = 4;
    localparam logic [DB-1:0] ONES = {DB{1'b1}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ext_mem_model_burst_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB)) bus();

    ext_mem_model_burst #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB), .DEPTH_LOG2(DL),
        .BURST_LEN(BL), .READ_LATENCY(RL), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected DUT handshake", name);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            addr;
        logic [TB-1:0] tag;
        bit            last;
    } beat_t;

    logic [DB-1:0] mm [int];
    beat_t         rdq[$];
    int            wrq[$];
    int            wbeat = 0;
    logic [DB-1:0] log_data[$];
    logic [TB-1:0] log_tag[$];
    bit            log_last[$];
    logic [DB-1:0] prev_data;
    logic [TB-1:0] prev_tag;
    bit            stalled = 0;

    function automatic int burst_base(input int a);
        return (a & ~(BL - 1)) & ((1 << DL) - 1);
    endfunction

    function automatic logic [DB-1:0] model_rd(input int a);
        return mm.exists(a) ? mm[a] : '0;
    endfunction

    function automatic void model_wr(input int a, input logic [DB-1:0] d, input logic [DB/8-1:0] m);
        logic [DB-1:0] v;
        v = model_rd(a);
        for (int b = 0; b < DB/8; b++)
            if (m[b]) v[b*8 +: 8] = d[b*8 +: 8];
        mm[a] = v;
    endfunction

    function automatic void model_enqueue(input bit rw, input int a, input logic [TB-1:0] t);
        int base;
        base = burst_base(a);
        if (rw) begin
            wrq.push_back(base);
        end else begin
            for (int i = 0; i < BL; i++) begin
                beat_t bt;
`ifdef EXT_MEM_WRAP_FIRST_EN
                bt.addr = base + ((a + i) % BL);
`else
                bt.addr = base + i;
`endif
                bt.tag  = t;
                bt.last = (i == BL - 1);
                rdq.push_back(bt);
            end
        end
    endfunction

    // Compare process: inputs change just after posedge, so negedge sees settled values.
    always @(negedge clk) begin
        if (reset) begin
            rdq.delete();
            wrq.delete();
            wbeat = 0;
            stalled = 0;
        end else begin
            if (bus.mem_req_valid && bus.mem_req_ready)
                model_enqueue(bus.mem_req_rw, int'(bus.mem_req_addr), bus.mem_req_tag);
            if (bus.mem_req_data_valid && bus.mem_req_data_ready) begin
                if (wrq.size() == 0) begin
                    check("unexpected_wdata_ready", DB'(bus.mem_req_data_ready), '0);
                end else begin
                    model_wr(wrq[0] + wbeat, bus.mem_req_data_bits, bus.mem_req_data_mask);
                    wbeat++;
                    if (wbeat == BL) begin
                        wbeat = 0;
                        void'(wrq.pop_front());
                    end
                end
            end
            if (bus.mem_resp_valid) begin
                if (stalled) begin
                    check("stall_data", bus.mem_resp_data, prev_data);
                    check("stall_tag", DB'(bus.mem_resp_tag), DB'(prev_tag));
                end
                if (rdq.size() == 0) begin
                    check("unexpected_resp_valid", DB'(bus.mem_resp_valid), '0);
                end else begin
                    check("resp_data", bus.mem_resp_data, model_rd(rdq[0].addr));
                    check("resp_tag", DB'(bus.mem_resp_tag), DB'(rdq[0].tag));
                    check("resp_last", DB'(bus.mem_resp_last), DB'(rdq[0].last));
                    if (bus.mem_resp_ready) begin
                        log_data.push_back(bus.mem_resp_data);
                        log_tag.push_back(bus.mem_resp_tag);
                        log_last.push_back(bus.mem_resp_last);
                        void'(rdq.pop_front());
                    end
                end
                stalled   = !bus.mem_resp_ready;
                prev_data = bus.mem_resp_data;
                prev_tag  = bus.mem_resp_tag;
            end else begin
                if (stalled) check("stall_valid_dropped", DB'(bus.mem_resp_valid), DB'(1));
                stalled = 0;
            end
        end
    end

    // ---------------- stimulus tasks (entered and left at posedge+1) ----------------
    task automatic send_req(input bit rw, input int a, input int t);
        bit ok;
        ok = 0;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = rw;
        bus.mem_req_addr  = AB'(a);
        bus.mem_req_tag   = TB'(t);
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = bus.mem_req_ready;
            @(posedge clk);
            #1;
        end
        bus.mem_req_valid = 1'b0;
        if (!ok) fail_timeout("req_accept");
    endtask

    task automatic send_wbeat(input logic [DB-1:0] d, input logic [DB/8-1:0] m);
        bit ok;
        ok = 0;
        bus.mem_req_data_valid = 1'b1;
        bus.mem_req_data_bits  = d;
        bus.mem_req_data_mask  = m;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = bus.mem_req_data_ready;
            @(posedge clk);
            #1;
        end
        bus.mem_req_data_valid = 1'b0;
        if (!ok) fail_timeout("wdata_accept");
    endtask

    task automatic write_burst(input int a, input logic [DB-1:0] first, input int step,
                               input logic [DB/8-1:0] m0, input logic [DB/8-1:0] mrest);
        send_req(1'b1, a, 0);
        for (int i = 0; i < BL; i++)
            send_wbeat(first + DB'(i * step), (i == 0) ? m0 : mrest);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rdq.size() != 0 || wrq.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) fail_timeout("wait_idle");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int L0;
        int first_n;
        int n;
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_rw         = 1'b0;
        bus.mem_req_addr       = '0;
        bus.mem_req_tag        = '0;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits  = '0;
        bus.mem_req_data_mask  = '0;
        bus.mem_resp_ready     = 1'b1;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req_ready", DB'(bus.mem_req_ready), '0);
        check("rst_resp_valid", DB'(bus.mem_resp_valid), '0);
        check("rst_data_ready", DB'(bus.mem_req_data_ready), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", DB'(bus.mem_req_ready), DB'(1));
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++)
            write_burst(4 * k, DB'(32'hD000_0000 + 4 * k), 1, '1, '1);

        // 1: aligned write then read, with latency
        write_burst('h10, DB'('hA0), 1, '1, '1);
        wait_idle();
        L0 = log_data.size();
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = AB'('h10);
        bus.mem_req_tag   = TB'(3);
        @(negedge clk);
        check("t1_req_ready", DB'(bus.mem_req_ready), DB'(1));
        @(posedge clk);
        #1;
        bus.mem_req_valid = 1'b0;
        first_n = 0;
        for (int k = 1; k <= 10 && first_n == 0; k++) begin
            @(negedge clk);
            if (bus.mem_resp_valid) first_n = k;
        end
        check("t1_first_beat_latency", DB'(first_n), DB'(4));
        @(posedge clk);
        #1;
        wait_idle();
        check("t1_beat_count", DB'(log_data.size() - L0), DB'(4));
        for (int i = 0; i < 4 && L0 + i < log_data.size(); i++) begin
            check("t1_data", log_data[L0+i], DB'('hA0 + i));
            check("t1_tag", DB'(log_tag[L0+i]), DB'(3));
            check("t1_last", DB'(log_last[L0+i]), DB'(i == 3));
        end

        // 2: partial mask on beat 0
        write_burst('h20, ONES, 0, '1, '1);
        write_burst('h20, '0, 0, 16'h0001, 16'h0000);
        L0 = log_data.size();
        send_req(1'b0, 'h20, 4);
        wait_idle();
        check("t2_beat_count", DB'(log_data.size() - L0), DB'(4));
        if (log_data.size() >= L0 + 4) begin
            check("t2_beat0", log_data[L0], {{(DB-8){1'b1}}, 8'h00});
            for (int i = 1; i < 4; i++) check("t2_beat_unchanged", log_data[L0+i], ONES);
        end

        // 3: backpressure on beat 1 for 5 cycles
        L0 = log_data.size();
        send_req(1'b0, 'h10, 7);
        n = 0;
        while (log_data.size() < L0 + 1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) fail_timeout("t3_first_beat");
        bus.mem_resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_stall_valid", DB'(bus.mem_resp_valid), DB'(1));
            check("t3_stall_data", bus.mem_resp_data, DB'('hA1));
            check("t3_stall_tag", DB'(bus.mem_resp_tag), DB'(7));
        end
        @(posedge clk);
        #1;
        bus.mem_resp_ready = 1'b1;
        wait_idle();
        check("t3_beat_count", DB'(log_data.size() - L0), DB'(4));
        for (int i = 0; i < 4 && L0 + i < log_data.size(); i++)
            check("t3_data", log_data[L0+i], DB'('hA0 + i));

        // 4: queue full with a stalled consumer
        bus.mem_resp_ready = 1'b0;
        L0 = log_data.size();
        for (int k = 0; k < 5; k++) send_req(1'b0, 4 * k, k);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_tag   = TB'(5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_full_ready", DB'(bus.mem_req_ready), '0);
        end
        @(posedge clk);
        #1;
        bus.mem_req_valid  = 1'b0;
        bus.mem_resp_ready = 1'b1;
        wait_idle();
        check("t4_beat_count", DB'(log_data.size() - L0), DB'(20));
        for (int i = 0; i < 20 && L0 + i < log_data.size(); i++)
            check("t4_tag_order", DB'(log_tag[L0+i]), DB'(i / 4));
        if (log_data.size() >= L0 + 5) check("t4_burst1_data", log_data[L0+4], DB'(32'hD000_0004));

        // 5: reset during beat 2 with two requests queued
        L0 = log_data.size();
        send_req(1'b0, 'h10, 1);
        send_req(1'b0, 'h4, 2);
        send_req(1'b0, 'h8, 3);
        n = 0;
        while (!(bus.mem_resp_valid && log_data.size() == L0 + 2) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) fail_timeout("t5_beat2");
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_resp_valid", DB'(bus.mem_resp_valid), '0);
        check("t5_rst_req_ready", DB'(bus.mem_req_ready), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_post_req_ready", DB'(bus.mem_req_ready), DB'(1));
        for (int k = 0; k < 6; k++) begin
            check("t5_queue_discarded", DB'(bus.mem_resp_valid), '0);
            @(negedge clk);
        end
        check("t5_beats_before_reset", DB'(log_data.size() - L0), DB'(2));
        @(posedge clk);
        #1;
        L0 = log_data.size();
        send_req(1'b0, 'h10, 9);
        wait_idle();
        check("t5_readback_count", DB'(log_data.size() - L0), DB'(4));
        for (int i = 0; i < 4 && L0 + i < log_data.size(); i++)
            check("t5_readback", log_data[L0+i], DB'('hA0 + i));

        // 6: unaligned read start
        L0 = log_data.size();
        send_req(1'b0, 'h12, 6);
        wait_idle();
        check("t6_beat_count", DB'(log_data.size() - L0), DB'(4));
        for (int i = 0; i < 4 && L0 + i < log_data.size(); i++) begin
`ifdef EXT_MEM_WRAP_FIRST_EN
            check("t6_order", log_data[L0+i], DB'('hA0 + ((i + 2) % 4)));
`else
            check("t6_order", log_data[L0+i], DB'('hA0 + i));
`endif
            check("t6_last", DB'(log_last[L0+i]), DB'(i == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected end of scenarios");
        $fatal(1);
    end
endmodule
